// File: rtl/pmod_clp_pkg.sv
// Shared types, LCD command constants and init ROM for the PmodCLP write sequencer.
// The init ROM is only consumed when PMOD_CLP_AUTOINIT_EN is defined.
package pmod_clp_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_EPULSE  = 3'd4,
        ST_HOLD    = 3'd5,
        ST_EXEC    = 3'd6
    } state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int unsigned INIT_LEN = 6;
    // Element 0 is issued first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        LCD_ENTRY, LCD_CLEAR, LCD_DISP_ON, LCD_FUNC_SET, LCD_FUNC_SET, LCD_FUNC_SET
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear (01) and return-home (02/03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == LCD_CLEAR) || (data[7:1] == 7'h01));
    endfunction

endpackage

// File: rtl/pmod_clp_ctrl_timer.sv
// clp_delay_timer: loadable down-counter shared by every timed state of the LCD sequencer.
// A load of N-1 yields N cycles before done is seen by the owner.
module clp_delay_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count_r;

    // Load wins over counting; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != '0) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/pmod_clp_ctrl.sv
// Write-only HD44780 sequencer for the PmodCLP: one byte per handshake, with setup/pulse/hold/exec timing.
// Define PMOD_CLP_AUTOINIT_EN to add the power-up wait and the built-in init command sequence.
module pmod_clp_ctrl
    import pmod_clp_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = 2_000_000,
    parameter int unsigned SETUP_CYC   = 5,
    parameter int unsigned EPW_CYC     = 25,
    parameter int unsigned HOLD_CYC    = 5,
    parameter int unsigned EXEC_CYC    = 4_000,
    parameter int unsigned CLR_CYC     = 164_000
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int unsigned PU_EFF    = (POWERUP_CYC == 32'd0) ? 32'd1 : POWERUP_CYC;
    localparam int unsigned SETUP_EFF = (SETUP_CYC == 32'd0) ? 32'd1 : SETUP_CYC;
    localparam int unsigned EPW_EFF   = (EPW_CYC == 32'd0) ? 32'd1 : EPW_CYC;
    localparam int unsigned HOLD_EFF  = (HOLD_CYC == 32'd0) ? 32'd1 : HOLD_CYC;
    localparam int unsigned EXEC_EFF  = (EXEC_CYC == 32'd0) ? 32'd1 : EXEC_CYC;
    localparam int unsigned CLR_EFF   = (CLR_CYC == 32'd0) ? 32'd1 : CLR_CYC;
    localparam int unsigned MAX_CYC   = max_u(max_u(max_u(PU_EFF, SETUP_EFF), max_u(EPW_EFF, HOLD_EFF)),
                                              max_u(EXEC_EFF, CLR_EFF));
    localparam int unsigned CW        = $clog2(MAX_CYC + 32'd1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_EFF - 32'd1);
    localparam logic [CW-1:0] EPW_LD   = CW'(EPW_EFF - 32'd1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_EFF - 32'd1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_EFF - 32'd1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_EFF - 32'd1);

`ifdef PMOD_CLP_AUTOINIT_EN
    localparam int unsigned    IDX_W       = $clog2(INIT_LEN + 32'd1);
    // First POWERUP cycle arms the timer and INIT takes one more, so load N-3.
    localparam logic [CW-1:0]  PU_LD       = CW'((PU_EFF > 32'd2) ? (PU_EFF - 32'd3) : 32'd0);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_LEN);
    localparam state_t         RESET_STATE = ST_POWERUP;
    logic                      armed_r;
    logic [IDX_W-1:0]          init_idx_r;
`else
    localparam state_t         RESET_STATE = ST_IDLE;
`endif

    state_t         state_r;
    logic           long_r;
    logic           accept_s;
    logic           tmr_load_s;
    logic [CW-1:0]  tmr_value_s;
    logic           tmr_done_s;

    assign accept_s = (state_r == ST_IDLE) && req_ready && req_valid;
    assign lcd_rw   = 1'b0;

    clp_delay_timer #(.W(CW)) u_timer (
        .clk   (sysclk),
        .rst   (sysreset),
        .load  (tmr_load_s),
        .value (tmr_value_s),
        .done  (tmr_done_s)
    );

    // Timer load requests: each timed state is entered with its length minus one.
    always_comb begin
        tmr_load_s  = 1'b0;
        tmr_value_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = SETUP_LD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_done_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = EPW_LD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_EPULSE: begin
                if (tmr_done_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = HOLD_LD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (tmr_done_s) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = long_r ? CLR_LD : EXEC_LD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
`ifdef PMOD_CLP_AUTOINIT_EN
            ST_POWERUP: begin
                if (!armed_r && (PU_EFF > 32'd2)) begin
                    tmr_load_s  = 1'b1;
                    tmr_value_s = PU_LD;
                end else begin
                    tmr_load_s  = 1'b0;
                end
            end
            ST_INIT: begin
                tmr_load_s  = 1'b1;
                tmr_value_s = SETUP_LD;
            end
`endif
            default: begin
                tmr_load_s  = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with all LCD pins and handshake outputs registered.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_r    <= RESET_STATE;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            long_r     <= 1'b0;
`ifdef PMOD_CLP_AUTOINIT_EN
            armed_r    <= 1'b0;
            init_idx_r <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lcd_rs    <= req_rs;
                        lcd_data  <= req_data;
                        long_r    <= is_long_cmd(req_rs, req_data);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ST_SETUP;
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done_s) begin
                        lcd_e   <= 1'b1;
                        state_r <= ST_EPULSE;
                    end
                end
                ST_EPULSE: begin
                    if (tmr_done_s) begin
                        lcd_e   <= 1'b0;
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done_s) begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (tmr_done_s) begin
`ifdef PMOD_CLP_AUTOINIT_EN
                        if (init_idx_r != INIT_LAST) begin
                            state_r <= ST_INIT;
                        end else begin
                            state_r   <= ST_IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end
`else
                        state_r   <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
`endif
                    end
                end
`ifdef PMOD_CLP_AUTOINIT_EN
                ST_POWERUP: begin
                    busy <= 1'b1;
                    if (!armed_r) begin
                        armed_r <= 1'b1;
                        state_r <= (PU_EFF > 32'd2) ? ST_POWERUP : ST_INIT;
                    end else if (tmr_done_s) begin
                        state_r <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    lcd_rs     <= 1'b0;
                    lcd_data   <= INIT_ROM[init_idx_r];
                    long_r     <= is_long_cmd(1'b0, INIT_ROM[init_idx_r]);
                    init_idx_r <= init_idx_r + IDX_W'(1);
                    state_r    <= ST_SETUP;
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    lcd_e     <= 1'b0;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_clp_ctrl.sv
// Self-checking bench for pmod_clp_ctrl with shortened timing; follows PMOD_CLP_AUTOINIT_EN if defined.
// A negedge monitor checks every write against a queue-based model of expected strobes and timing.
module tb_pmod_clp_ctrl;

    localparam int P = 10, S = 2, E = 3, H = 2, X = 8, C = 20;

    logic       sysclk = 1'b0;
    logic       sysreset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    pmod_clp_ctrl #(
        .POWERUP_CYC(P), .SETUP_CYC(S), .EPW_CYC(E),
        .HOLD_CYC(H), .EXEC_CYC(X), .CLR_CYC(C)
    ) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data),
        .busy(busy), .init_done(init_done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } pulse_t;

    pulse_t     pq[$];
    int         acc_q[$];
    int         tests = 0, fails = 0;
    bit         in_flight = 1'b0, have_byte = 1'b0, pulse_on = 1'b0;
    int         ret_cyc = 0, byte_eff = 0, rise_seen = 0;
    int         rel_cyc = 32'h3FFF_FFFF, done_cyc = 32'h3FFF_FFFF;
    logic       exp_rs = 1'b0, prev_e = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Busy time of one write: setup + pulse + hold + the command's execution wait.
    function automatic int occ(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d inside {8'h01, 8'h02, 8'h03}))
            return S + E + H + C;
        return S + E + H + X;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        sysreset = 1'b1;
        @(posedge sysclk); #1;
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        @(posedge sysclk); #2;
        sysreset = 1'b0;
        rel_cyc = cyc;
`ifdef PMOD_CLP_AUTOINIT_EN
        begin
            int l;
            l = rel_cyc + P;
            for (int i = 0; i < 6; i++) begin
                pq.push_back('{1'b0, rom[i], l + S});
                if (i < 5) l = l + occ(1'b0, rom[i]) + 1;
            end
            ret_cyc  = l + occ(1'b0, rom[5]);
            done_cyc = ret_cyc;
        end
`else
        ret_cyc  = rel_cyc + 1;
        done_cyc = rel_cyc + 1;
`endif
        in_flight = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("ready_timeout", ok, 1'b1);
        @(posedge sysclk); #2;
    endtask

    task automatic drive_req(input logic rs, input logic [7:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_rs = rs; req_data = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge sysclk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", ok, 1'b1);
        @(posedge sysclk); #2;
        if (!keep) begin
            req_valid = 1'b0; req_rs = 1'($urandom); req_data = 8'($urandom);
        end
    endtask

    initial begin
        // Monitor: model of expected strobes, handshake timing and held outputs.
        fork
            forever begin
                pulse_t p;
                int     k;
                @(negedge sysclk);
                if (sysreset) begin
                    pq.delete(); in_flight = 1'b0; have_byte = 1'b0; pulse_on = 1'b0;
                end else begin
                    chk("rw_low", lcd_rw, 1'b0);
                    if (cyc > rel_cyc) begin
                        chk("busy_vs_ready", busy, !req_ready);
                        chk("init_done", init_done, cyc >= done_cyc);
                    end
                    if (in_flight) begin
                        if (cyc < ret_cyc) chk("ready_low", req_ready, 1'b0);
                        else begin chk("ready_back", req_ready, 1'b1); in_flight = 1'b0; end
                    end
                    if (have_byte && cyc >= byte_eff) begin
                        chk("data_hold", lcd_data, exp_data);
                        chk("rs_hold", lcd_rs, exp_rs);
                    end
                    if (lcd_e && !prev_e) begin
                        if (pq.size() == 0) chk("unexpected_pulse", 1'b1, 1'b0);
                        else begin
                            p = pq.pop_front();
                            chk("pulse_start", cyc, p.rise);
                            chk("pulse_data", lcd_data, p.data);
                            chk("pulse_rs", lcd_rs, p.rs);
                            rise_seen = cyc; pulse_on = 1'b1;
                        end
                    end
                    if (!lcd_e && prev_e && pulse_on) begin
                        chk("pulse_width", cyc - rise_seen, E);
                        pulse_on = 1'b0;
                    end
                    if (req_valid && req_ready) begin
                        k = cyc + 1;
                        acc_q.push_back(k);
                        pq.push_back('{req_rs, req_data, k + S});
                        in_flight = 1'b1; ret_cyc = k + occ(req_rs, req_data);
                        have_byte = 1'b1; exp_rs = req_rs; exp_data = req_data; byte_eff = k;
                    end
                end
                prev_e = lcd_e;
            end
        join_none

        repeat (2) @(posedge sysclk);
        #2;
        apply_reset();
        wait_ready(400);

        // Single character write.
        drive_req(1'b1, 8'h41, 1'b0);
        @(negedge sysclk);
        chk("t1_ready_drop", req_ready, 1'b0);
        chk("t1_data", lcd_data, 8'h41);
        chk("t1_rs", lcd_rs, 1'b1);
        wait_ready(100);

        // Long and short command classification.
        drive_req(1'b0, 8'h01, 1'b0); wait_ready(100);
        drive_req(1'b0, 8'h02, 1'b0); wait_ready(100);
        drive_req(1'b1, 8'h01, 1'b0); wait_ready(100);
        drive_req(1'b0, 8'h03, 1'b0); wait_ready(100);
        drive_req(1'b0, 8'h04, 1'b0); wait_ready(100);

        // Back-to-back with req_valid held high.
        acc_q.delete();
        drive_req(1'b1, 8'h41, 1'b1);
        drive_req(1'b1, 8'h42, 1'b1);
        drive_req(1'b1, 8'h43, 1'b0);
        wait_ready(100);
        chk("t4_accepts", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("t4_gap1", acc_q[1] - acc_q[0], occ(1'b1, 8'h41) + 1);
            chk("t4_gap2", acc_q[2] - acc_q[1], occ(1'b1, 8'h42) + 1);
        end

        // Requests while busy are ignored.
        drive_req(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'(i % 2 == 0); req_data = 8'($urandom); req_rs = 1'($urandom);
            @(posedge sysclk); #2;
        end
        req_valid = 1'b0;
        @(negedge sysclk);
        chk("t6_data_kept", lcd_data, 8'h55);
        wait_ready(100);

        // Reset during the enable pulse discards the byte.
        drive_req(1'b1, 8'h5A, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge sysclk);
                if (lcd_e) begin seen = 1'b1; break; end
            end
            chk("t5_pulse_seen", seen, 1'b1);
        end
        @(posedge sysclk); #2;
        apply_reset();
        repeat (40) @(posedge sysclk);
        #2;
        wait_ready(400);

        // Randomized traffic with idle gaps and junk on the request fields.
        for (int n = 0; n < 12; n++) begin
            logic       rs;
            logic [7:0] d;
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                req_data = 8'($urandom); @(posedge sysclk); #2;
            end
            drive_req(rs, d, 1'b0);
        end

        begin
            bit drained;
            drained = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge sysclk);
                if (pq.size() == 0 && !in_flight) begin drained = 1'b1; break; end
            end
            chk("drain", drained, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
